// File: rtl/pipelined_mips_core.sv
// Five-stage MIPS core (IF/ID/EX/MEM/WB) with full forwarding, load-use stall
// and taken-branch flush; register file and data memory are internal.
module pipelined_mips_core #(
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        flush
);
  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [31:0] pc_r, ifid_instr_r, ifid_pc4_r;
  logic        idex_reg_write_r, idex_mem_read_r, idex_mem_write_r, idex_branch_r, idex_alu_src_r;
  alu_op_t     idex_alu_op_r;
  logic [4:0]  idex_rs_r, idex_rt_r, idex_dest_r;
  logic [31:0] idex_a_r, idex_b_r, idex_imm_r, idex_pc4_r;
  logic        exmem_reg_write_r, exmem_mem_read_r, exmem_mem_write_r;
  logic [4:0]  exmem_dest_r;
  logic [31:0] exmem_alu_r, exmem_store_r;
  logic [31:0] rf_r   [32];
  logic [31:0] dmem_r [DMEM_DEPTH];

  logic [5:0]  id_op_s, id_funct_s;
  logic [4:0]  id_rs_s, id_rt_s, id_rd_s, dec_dest_s;
  logic [31:0] id_imm_s, id_a_s, id_b_s;
  logic        dec_rw_s, dec_mem_read_s, dec_mem_write_s, dec_branch_s, dec_alu_src_s;
  alu_op_t     dec_alu_op_s;
  logic        id_reads_rt_s, load_use_s;
  logic [31:0] ex_a_s, ex_b_s, ex_alu_b_s, ex_alu_s, ex_target_s;
  logic [AW-1:0] mem_idx_s;

  assign id_op_s    = ifid_instr_r[31:26];
  assign id_rs_s    = ifid_instr_r[25:21];
  assign id_rt_s    = ifid_instr_r[20:16];
  assign id_rd_s    = ifid_instr_r[15:11];
  assign id_funct_s = ifid_instr_r[5:0];
  assign id_imm_s   = {{16{ifid_instr_r[15]}}, ifid_instr_r[15:0]};
  assign imem_addr  = pc_r;

  // Main decoder; anything unrecognised falls through as a nop.
  always_comb begin
    dec_rw_s        = 1'b0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_branch_s    = 1'b0;
    dec_alu_src_s   = 1'b0;
    dec_alu_op_s    = ALU_ADD;
    dec_dest_s      = 5'd0;
    case (id_op_s)
      OP_RTYPE: begin
        dec_dest_s = id_rd_s;
        case (id_funct_s)
          6'h20:   begin dec_rw_s = 1'b1; dec_alu_op_s = ALU_ADD; end
          6'h22:   begin dec_rw_s = 1'b1; dec_alu_op_s = ALU_SUB; end
          6'h24:   begin dec_rw_s = 1'b1; dec_alu_op_s = ALU_AND; end
          6'h25:   begin dec_rw_s = 1'b1; dec_alu_op_s = ALU_OR;  end
          6'h2a:   begin dec_rw_s = 1'b1; dec_alu_op_s = ALU_SLT; end
          default: dec_rw_s = 1'b0;
        endcase
      end
      OP_ADDI: begin dec_rw_s = 1'b1; dec_alu_src_s = 1'b1; dec_dest_s = id_rt_s; end
      OP_ANDI: begin dec_rw_s = 1'b1; dec_alu_src_s = 1'b1; dec_dest_s = id_rt_s; dec_alu_op_s = ALU_AND; end
      OP_ORI:  begin dec_rw_s = 1'b1; dec_alu_src_s = 1'b1; dec_dest_s = id_rt_s; dec_alu_op_s = ALU_OR; end
      OP_LW:   begin dec_rw_s = 1'b1; dec_mem_read_s = 1'b1; dec_alu_src_s = 1'b1; dec_dest_s = id_rt_s; end
      OP_SW:   begin dec_mem_write_s = 1'b1; dec_alu_src_s = 1'b1; end
      OP_BEQ:  dec_branch_s = 1'b1;
      default: dec_rw_s = 1'b0;
    endcase
  end

  // Register read with write-through from the committing WB instruction.
  always_comb begin
    if (wb_valid && (wb_addr == id_rs_s)) id_a_s = wb_data;
    else                                  id_a_s = rf_r[id_rs_s];
    if (wb_valid && (wb_addr == id_rt_s)) id_b_s = wb_data;
    else                                  id_b_s = rf_r[id_rt_s];
  end

  assign id_reads_rt_s = (id_op_s == OP_RTYPE) || (id_op_s == OP_BEQ) || (id_op_s == OP_SW);
  assign load_use_s    = idex_mem_read_r && (idex_dest_r != 5'd0) &&
                         ((id_rs_s == idex_dest_r) || (id_reads_rt_s && (id_rt_s == idex_dest_r)));

  // Operand forwarding: a load in EX/MEM has no result yet, so it is skipped there.
  always_comb begin
    if (exmem_reg_write_r && !exmem_mem_read_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rs_r))
      ex_a_s = exmem_alu_r;
    else if (wb_valid && (wb_addr == idex_rs_r))
      ex_a_s = wb_data;
    else
      ex_a_s = idex_a_r;
    if (exmem_reg_write_r && !exmem_mem_read_r && (exmem_dest_r != 5'd0) && (exmem_dest_r == idex_rt_r))
      ex_b_s = exmem_alu_r;
    else if (wb_valid && (wb_addr == idex_rt_r))
      ex_b_s = wb_data;
    else
      ex_b_s = idex_b_r;
  end

  assign ex_alu_b_s  = idex_alu_src_r ? idex_imm_r : ex_b_s;
  assign ex_target_s = idex_pc4_r + {idex_imm_r[29:0], 2'b00};

  // ALU.
  always_comb begin
    case (idex_alu_op_r)
      ALU_ADD: ex_alu_s = ex_a_s + ex_alu_b_s;
      ALU_SUB: ex_alu_s = ex_a_s - ex_alu_b_s;
      ALU_AND: ex_alu_s = ex_a_s & ex_alu_b_s;
      ALU_OR:  ex_alu_s = ex_a_s | ex_alu_b_s;
      ALU_SLT: ex_alu_s = {31'd0, ($signed(ex_a_s) < $signed(ex_alu_b_s))};
      default: ex_alu_s = 32'd0;
    endcase
  end

  assign flush     = idex_branch_r && (ex_a_s == ex_b_s);
  assign stall     = load_use_s && !flush;
  assign mem_idx_s = exmem_alu_r[AW+1:2];

  // Pipeline registers and PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= PC_RESET;
      ifid_instr_r <= 32'd0; ifid_pc4_r <= 32'd0;
      idex_reg_write_r <= 1'b0; idex_mem_read_r <= 1'b0; idex_mem_write_r <= 1'b0;
      idex_branch_r <= 1'b0; idex_alu_src_r <= 1'b0; idex_alu_op_r <= ALU_ADD;
      idex_rs_r <= 5'd0; idex_rt_r <= 5'd0; idex_dest_r <= 5'd0;
      idex_a_r <= 32'd0; idex_b_r <= 32'd0; idex_imm_r <= 32'd0; idex_pc4_r <= 32'd0;
      exmem_reg_write_r <= 1'b0; exmem_mem_read_r <= 1'b0; exmem_mem_write_r <= 1'b0;
      exmem_dest_r <= 5'd0; exmem_alu_r <= 32'd0; exmem_store_r <= 32'd0;
      wb_valid <= 1'b0; wb_addr <= 5'd0; wb_data <= 32'd0;
    end else begin
      if (flush)      pc_r <= ex_target_s;
      else if (!stall) pc_r <= pc_r + 32'd4;

      if (flush) begin
        ifid_instr_r <= 32'd0; ifid_pc4_r <= 32'd0;
      end else if (!stall) begin
        ifid_instr_r <= imem_instr; ifid_pc4_r <= pc_r + 32'd4;
      end

      if (flush || stall) begin
        idex_reg_write_r <= 1'b0; idex_mem_read_r <= 1'b0; idex_mem_write_r <= 1'b0;
        idex_branch_r <= 1'b0; idex_alu_src_r <= 1'b0; idex_alu_op_r <= ALU_ADD;
        idex_rs_r <= 5'd0; idex_rt_r <= 5'd0; idex_dest_r <= 5'd0;
        idex_a_r <= 32'd0; idex_b_r <= 32'd0; idex_imm_r <= 32'd0; idex_pc4_r <= 32'd0;
      end else begin
        idex_reg_write_r <= dec_rw_s && (dec_dest_s != 5'd0);
        idex_mem_read_r <= dec_mem_read_s; idex_mem_write_r <= dec_mem_write_s;
        idex_branch_r <= dec_branch_s; idex_alu_src_r <= dec_alu_src_s; idex_alu_op_r <= dec_alu_op_s;
        idex_rs_r <= id_rs_s; idex_rt_r <= id_rt_s; idex_dest_r <= dec_dest_s;
        idex_a_r <= id_a_s; idex_b_r <= id_b_s; idex_imm_r <= id_imm_s; idex_pc4_r <= ifid_pc4_r;
      end

      exmem_reg_write_r <= idex_reg_write_r; exmem_mem_read_r <= idex_mem_read_r;
      exmem_mem_write_r <= idex_mem_write_r; exmem_dest_r <= idex_dest_r;
      exmem_alu_r <= ex_alu_s; exmem_store_r <= ex_b_s;

      wb_valid <= exmem_reg_write_r;
      wb_addr  <= exmem_dest_r;
      wb_data  <= exmem_mem_read_r ? dmem_r[mem_idx_s] : exmem_alu_r;
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
    end else if (wb_valid && (wb_addr != 5'd0)) begin
      rf_r[wb_addr] <= wb_data;
    end
  end

  // Data memory, written at the end of MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_r[i] <= 32'd0;
    end else if (exmem_mem_write_r) begin
      dmem_r[mem_idx_s] <= exmem_store_r;
    end
  end
endmodule
